// File: rtl/pass_arbiter_if.sv
// Handshake bundle between N producer ports, the arbiter and one consumer.
// The master modport is the arbiter's view. The slave modport is the view of the
// environment that drives the producers and the consumer.
interface pass_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    // Producer side
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_last;

    // Consumer side
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic [IDW-1:0]     out_id;

    // Status
    logic               busy;
    logic               err_timeout;

    modport master (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_id, busy, err_timeout
    );

    modport slave (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_id, busy, err_timeout
    );
endinterface

// File: rtl/pass_arbiter.sv
// Packet-level round-robin arbiter in front of a single registered pass stage.
// A requester keeps the grant from its first beat until its last beat is
// accepted. An optional watchdog frees the grant when the owner stalls.
module pass_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int WATCHDOG = 0
) (
    input  logic            clock,
    input  logic            reset,
    pass_arbiter_if.master  bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int WDW = (WATCHDOG > 0) ? $clog2(WATCHDOG + 1) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Advance a requester index by one, wrapping N-1 back to 0 for any N.
    function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] v);
        if (int'(v) == N - 1) begin
            return '0;
        end
        return v + IDW'(1);
    endfunction

    // Index of the k-th candidate in round-robin order starting at ptr.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= N) begin
            s = s - N;
        end
        return IDW'(s);
    endfunction

    // Registered state
    logic [0:0]       state_q,       state_d;
    logic [IDW-1:0]   owner_q,       owner_d;
    logic [IDW-1:0]   rr_ptr_q,      rr_ptr_d;
    logic [WDW-1:0]   wd_cnt_q,      wd_cnt_d;
    logic             out_valid_q,   out_valid_d;
    logic [WIDTH-1:0] out_data_q,    out_data_d;
    logic             out_last_q,    out_last_d;
    logic [IDW-1:0]   out_id_q,      out_id_d;
    logic             err_timeout_q, err_timeout_d;

    // Arbitration terms
    logic             locked;
    logic             slot_free;
    logic             any_valid;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   sel;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic [N-1:0]     grant;
    logic             xfer;

    // Round-robin search for the first valid requester starting at rr_ptr.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        any_valid = 1'b0;
        winner    = '0;
        for (int k = 0; k < N; k++) begin
            if (!any_valid && bus.in_valid[rr_index(rr_ptr_q, k)]) begin
                any_valid = 1'b1;
                winner    = rr_index(rr_ptr_q, k);
            end
        end
    end

    // Grant: the lock owner while LOCKED, otherwise the round-robin winner.
    always_comb begin
        locked    = (state_q == ST_LOCKED);
        slot_free = ~out_valid_q | bus.out_ready;
        sel       = locked ? owner_q : winner;
        sel_valid = locked ? bus.in_valid[sel] : any_valid;
        sel_data  = bus.in_data[int'(sel)*WIDTH +: WIDTH];
        sel_last  = bus.in_last[sel];
        grant     = '0;
        if (!reset && (locked || any_valid)) begin
            grant[sel] = slot_free;
        end
        xfer      = sel_valid & grant[sel];
    end

    // Next-state logic for the lock FSM, output register and watchdog.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        wd_cnt_d      = wd_cnt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        out_id_d      = out_id_q;
        err_timeout_d = 1'b0;

        // Output register: load on transfer, drain when the consumer takes it.
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_id_d    = sel;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (sel_last) begin
                        rr_ptr_d = inc_mod(sel);
                    end else begin
                        state_d  = ST_LOCKED;
                        owner_d  = sel;
                        wd_cnt_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    wd_cnt_d = '0;
                    if (sel_last) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = inc_mod(owner_q);
                    end
                end else if (WATCHDOG > 0 && !bus.in_valid[owner_q]) begin
                    wd_cnt_d = wd_cnt_q + WDW'(1);
                    // The truncated packet is abandoned; the output register
                    // is not touched.
                    if (wd_cnt_d == WDW'(WATCHDOG)) begin
                        err_timeout_d = 1'b1;
                        state_d       = ST_IDLE;
                        rr_ptr_d      = inc_mod(owner_q);
                        wd_cnt_d      = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a reset discards any held beat.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            wd_cnt_q      <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            out_id_q      <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            wd_cnt_q      <= wd_cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            out_id_q      <= out_id_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.in_ready    = grant;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_id      = out_id_q;
    assign bus.busy        = (state_q == ST_LOCKED);
    assign bus.err_timeout = err_timeout_q;

    // At most one requester is ever granted.
    a_grant_onehot: assert property (@(posedge clock) $onehot0(grant));

endmodule
